// File: rtl/branch_resolve_if.sv
// Execute-to-fetch-redirect channel for branch_resolve: branch request side,
// resolved result side and the pipeline flush. The slave modport is the resolver's view.
interface branch_resolve_if #(
    parameter int AW = 32
);
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    cond;
    logic          gt;
    logic          lt;
    logic          eq;
    logic [AW-1:0] pc;
    logic [AW-1:0] offset;
    logic          pred_taken;
    logic          out_valid;
    logic          out_ready;
    logic          taken;
    logic [AW-1:0] next_pc;
    logic          mispredict;

    modport master (
        output flush, in_valid, cond, gt, lt, eq, pc, offset, pred_taken, out_ready,
        input  in_ready, out_valid, taken, next_pc, mispredict
    );

    modport slave (
        input  flush, in_valid, cond, gt, lt, eq, pc, offset, pred_taken, out_ready,
        output in_ready, out_valid, taken, next_pc, mispredict
    );
endinterface

// File: rtl/branch_resolve.sv
// Branch resolver: condition decode, next-PC and mispredict, behind a 2-entry skid buffer.
// Optional BRANCH_RESOLVE_STATS_EN adds saturating transfer/mispredict counters.
//
// state     | meaning
// ST_EMPTY  | nothing held, out_valid low
// ST_ONE    | entry 0 (output register) holds a result
// ST_FULL   | entries 0 and 1 hold results, in_ready low
module branch_resolve #(
    parameter int AW  = 32,
    parameter int INC = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    branch_resolve_if.slave br
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    output logic [15:0]    stat_branches_o,
    output logic [15:0]    stat_mispred_o
`endif
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          in_ready_q, in_ready_d;
    logic          e0_taken_q, e0_mis_q, e1_taken_q, e1_mis_q;
    logic [AW-1:0] e0_pc_q, e1_pc_q;

    logic          lt_qual;
    logic          res_taken;
    logic [AW-1:0] res_pc;
    logic          res_mis;
    logic          accept, drain;
    logic          load_e0_new, load_e0_e1, load_e1;

    // The comparator asserts lt on equality too, so qualify it with eq.
    assign lt_qual = br.lt & ~br.eq;

    always_comb begin
        res_taken = 1'b0;
        case (br.cond)
            3'b000:  res_taken = br.eq;
            3'b001:  res_taken = ~br.eq;
            3'b010:  res_taken = lt_qual;
            3'b011:  res_taken = br.gt | br.eq;
            3'b100:  res_taken = br.gt;
            3'b101:  res_taken = lt_qual | br.eq;
            3'b110:  res_taken = 1'b1;
            default: res_taken = 1'b0;
        endcase
    end

    assign res_pc  = res_taken ? (br.pc + br.offset) : (br.pc + AW'(INC));
    assign res_mis = res_taken ^ br.pred_taken;

    assign accept = br.in_valid & in_ready_q;
    assign drain  = (state_q != ST_EMPTY) & br.out_ready;

    always_comb begin
        state_d     = state_q;
        load_e0_new = 1'b0;
        load_e0_e1  = 1'b0;
        load_e1     = 1'b0;
        if (br.flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        load_e0_new = 1'b1;
                        state_d     = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        load_e0_new = 1'b1;
                    end else if (accept) begin
                        load_e1 = 1'b1;
                        state_d = ST_FULL;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        load_e0_e1 = 1'b1;
                        state_d    = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        in_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b0;
            e0_taken_q <= 1'b0;
            e0_pc_q    <= '0;
            e0_mis_q   <= 1'b0;
            e1_taken_q <= 1'b0;
            e1_pc_q    <= '0;
            e1_mis_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            if (load_e0_new) begin
                e0_taken_q <= res_taken;
                e0_pc_q    <= res_pc;
                e0_mis_q   <= res_mis;
            end else if (load_e0_e1) begin
                e0_taken_q <= e1_taken_q;
                e0_pc_q    <= e1_pc_q;
                e0_mis_q   <= e1_mis_q;
            end
            if (load_e1) begin
                e1_taken_q <= res_taken;
                e1_pc_q    <= res_pc;
                e1_mis_q   <= res_mis;
            end
        end
    end

    assign br.in_ready   = in_ready_q;
    assign br.out_valid  = (state_q != ST_EMPTY);
    assign br.taken      = e0_taken_q;
    assign br.next_pc    = e0_pc_q;
    assign br.mispredict = e0_mis_q;

`ifdef BRANCH_RESOLVE_STATS_EN
    logic [15:0] stat_br_q, stat_mp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            if (drain && (stat_br_q != 16'hFFFF))
                stat_br_q <= stat_br_q + 16'd1;
            if (drain && e0_mis_q && (stat_mp_q != 16'hFFFF))
                stat_mp_q <= stat_mp_q + 16'd1;
        end
    end

    assign stat_branches_o = stat_br_q;
    assign stat_mispred_o  = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: directed cases, backpressure, flush and random traffic.
module tb_branch_resolve;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_resolve_if #(.AW(32)) bus ();

`ifdef BRANCH_RESOLVE_STATS_EN
    logic [15:0] stat_b, stat_m;
    branch_resolve #(.AW(32), .INC(4)) dut (
        .clk(clk), .rst_n(rst_n), .br(bus),
        .stat_branches_o(stat_b), .stat_mispred_o(stat_m)
    );
`else
    branch_resolve #(.AW(32), .INC(4)) dut (.clk(clk), .rst_n(rst_n), .br(bus));
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_pops   = 0;
    int exp_br   = 0;
    int exp_mp   = 0;
    logic [33:0] exp_q [$];
    logic [33:0] e;

    // Reference: {taken, next_pc, mispredict} straight from the condition table.
    function automatic logic [33:0] model(input logic [2:0] c, input logic g, input logic l,
                                          input logic q, input logic [31:0] p,
                                          input logic [31:0] o, input logic pr);
        bit below, t;
        logic [31:0] nxt;
        below = l && !q;
        case (c)
            3'd0: t = q;
            3'd1: t = !q;
            3'd2: t = below;
            3'd3: t = g || q;
            3'd4: t = g;
            3'd5: t = below || q;
            3'd6: t = 1'b1;
            default: t = 1'b0;
        endcase
        nxt = t ? (p + o) : (p + 32'd4);
        return {t, nxt, t != pr};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    // Monitor/scoreboard: pop on output transfer, push on input transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!bus.flush && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got next_pc 0x%08h, expected no output",
                             bus.next_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_taken", {31'd0, bus.taken}, {31'd0, e[33]});
                    chk("sb_next_pc", bus.next_pc, e[32:1]);
                    chk("sb_mispredict", {31'd0, bus.mispredict}, {31'd0, e[0]});
                    n_pops++;
                    if (exp_br < 65535) exp_br++;
                    if (e[0] && exp_mp < 65535) exp_mp++;
                end
            end
            if (bus.flush) exp_q.delete();
            else if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.cond, bus.gt, bus.lt, bus.eq, bus.pc, bus.offset,
                                      bus.pred_taken));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [2:0] c, input logic g, input logic l,
                          input logic q, input logic [31:0] p, input logic [31:0] o,
                          input logic pr);
        bus.in_valid = v; bus.cond = c; bus.gt = g; bus.lt = l; bus.eq = q;
        bus.pc = p; bus.offset = o; bus.pred_taken = pr;
    endtask

    task automatic directed(input string nm, input logic [2:0] c, input logic g, input logic l,
                            input logic q, input logic [31:0] p, input logic [31:0] o,
                            input logic pr, input logic xt, input logic [31:0] xpc,
                            input logic xm);
        set_in(1'b1, c, g, l, q, p, o, pr);
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({nm, "_taken"}, {31'd0, bus.taken}, {31'd0, xt});
        chk({nm, "_next_pc"}, bus.next_pc, xpc);
        chk({nm, "_mispredict"}, {31'd0, bus.mispredict}, {31'd0, xm});
        step();
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        set_in(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_taken", {31'd0, bus.taken}, 32'd0);
        chk("rst_next_pc", bus.next_pc, 32'd0);
        chk("rst_mispredict", {31'd0, bus.mispredict}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        directed("eq_taken", 3'd0, 1'b0, 1'b1, 1'b1, 32'h100, 32'h20, 1'b0, 1'b1, 32'h120, 1'b1);
        directed("lt_equal", 3'd2, 1'b0, 1'b1, 1'b1, 32'h100, 32'h20, 1'b0, 1'b0, 32'h104, 1'b0);
        directed("wrap", 3'd6, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h10, 1'b1, 1'b1, 32'h8, 1'b0);
        directed("neg_off", 3'd6, 1'b0, 1'b0, 1'b0, 32'h200, 32'hFFFF_FFF0, 1'b1,
                 1'b1, 32'h1F0, 1'b0);
        directed("le_lt", 3'd5, 1'b0, 1'b1, 1'b0, 32'h300, 32'h40, 1'b1, 1'b1, 32'h340, 1'b0);
        directed("ge_less", 3'd3, 1'b0, 1'b1, 1'b0, 32'h400, 32'h40, 1'b1, 1'b0, 32'h404, 1'b1);
        directed("never", 3'd7, 1'b1, 1'b0, 1'b0, 32'h500, 32'h40, 1'b0, 1'b0, 32'h504, 1'b0);

        // Backpressure: two accepted, third blocked, then in-order drain.
        bus.out_ready = 1'b0;
        set_in(1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 32'h1000, 32'h10, 1'b1);
        step();
        set_in(1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 32'h2000, 32'h10, 1'b0);
        step();
        set_in(1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 32'h3000, 32'h10, 1'b1);
        chk("bp_in_ready_full", {31'd0, bus.in_ready}, 32'd0);
        step();
        chk("bp_in_ready_held", {31'd0, bus.in_ready}, 32'd0);
        base = n_pops;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_first", bus.next_pc, 32'h1010);
        step();
        @(negedge clk);
        chk("bp_second", bus.next_pc, 32'h2004);
        chk("bp_second_valid", {31'd0, bus.out_valid}, 32'd1);
        step();
        @(negedge clk);
        chk("bp_empty", {31'd0, bus.out_valid}, 32'd0);
        chk("bp_pop_count", n_pops - base, 32'd2);

        // Flush from FULL with an input offered.
        bus.out_ready = 1'b0;
        step();
        set_in(1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 32'h4000, 32'h4, 1'b0);
        step();
        set_in(1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 32'h4100, 32'h4, 1'b0);
        step();
        set_in(1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 32'h5000, 32'h4, 1'b0);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_full_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("flush_full_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush_full_quiet", {31'd0, bus.out_valid}, 32'd0);
        end

        // Flush from ONE while an input really handshakes.
        bus.out_ready = 1'b0;
        set_in(1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 32'h6000, 32'h4, 1'b0);
        step();
        set_in(1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 32'h7000, 32'h4, 1'b0);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_one_valid", {31'd0, bus.out_valid}, 32'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush_one_quiet", {31'd0, bus.out_valid}, 32'd0);
        end

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            bus.flush = ($urandom_range(0, 31) == 0);
            bus.out_ready = bus.flush ? 1'b0 : ($urandom_range(0, 2) != 0);
            set_in($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 1'($urandom),
                   1'($urandom), 1'($urandom), $urandom,
                   ($urandom_range(0, 1) != 0) ? $urandom : 32'($signed(12'($urandom))),
                   1'($urandom));
            step();
        end
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
        chk("drain_empty", exp_q.size(), 32'd0);

`ifdef BRANCH_RESOLVE_STATS_EN
        @(negedge clk);
        chk("stat_model_br", {16'd0, stat_b}, exp_br);
        chk("stat_model_mp", {16'd0, stat_m}, exp_mp);
        base = int'(stat_b);
        begin
            int base_m;
            base_m = int'(stat_m);
            directed("s1", 3'd6, 1'b0, 1'b0, 1'b0, 32'h10, 32'h4, 1'b1, 1'b1, 32'h14, 1'b0);
            directed("s2", 3'd6, 1'b0, 1'b0, 1'b0, 32'h10, 32'h4, 1'b0, 1'b1, 32'h14, 1'b1);
            directed("s3", 3'd7, 1'b0, 1'b0, 1'b0, 32'h10, 32'h4, 1'b0, 1'b0, 32'h14, 1'b0);
            directed("s4", 3'd7, 1'b0, 1'b0, 1'b0, 32'h10, 32'h4, 1'b1, 1'b0, 32'h14, 1'b1);
            directed("s5", 3'd6, 1'b0, 1'b0, 1'b0, 32'h10, 32'h4, 1'b1, 1'b1, 32'h14, 1'b0);
            @(negedge clk);
            chk("stat_five", int'(stat_b) - base, 32'd5);
            chk("stat_two_mp", int'(stat_m) - base_m, 32'd2);
        end
        set_in(1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 32'h20, 32'h8, 1'b0);
        bus.out_ready = 1'b1;
        repeat (65600) step();
        bus.in_valid = 1'b0;
        repeat (4) step();
        @(negedge clk);
        chk("stat_sat_br", {16'd0, stat_b}, 32'h0000_FFFF);
        chk("stat_sat_mp", {16'd0, stat_m}, 32'h0000_FFFF);
        chk("stat_sat_model", {16'd0, stat_b}, exp_br);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Consumes the gt/lt/eq flags produced by the 32-bit comparator in the execute stage, together with a branch condition code, PC and offset.
- Decides taken/not-taken and computes the next PC. Flags a mispredict against the fetch-stage prediction.
- Sits between execute and the fetch redirect path. Ready/valid on both sides, 1-cycle registered output, 2-entry skid buffer.

Parameters:
- AW, 32, PC/offset/target width.
- INC, 4, byte increment for fall-through PC.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline flush, drops all held entries
- in_valid  in  1  execute stage presents a branch
- in_ready  out  1  block can accept
- cond  in  3  condition code (encoding below)
- gt  in  1  comparator a>b
- lt  in  1  comparator "not gt" (asserted also when equal)
- eq  in  1  comparator a==b
- pc  in  AW  branch instruction PC
- offset  in  AW  two's-complement branch offset
- pred_taken  in  1  fetch-stage prediction
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- taken  out  1  branch resolved taken
- next_pc  out  AW  resolved next PC
- mispredict  out  1  taken != pred_taken

Behaviour:
- Reset (rst_n low, async): out_valid=0, taken=0, next_pc=0, mispredict=0, both skid entries invalid. in_ready=1 on the first clock edge after deassertion.
- Input transfer on in_valid&in_ready; output transfer on out_valid&out_ready.
- The lt input is not trusted alone. The block uses lt_q = lt & ~eq.
- Condition decode:
  - 000 EQ: eq
  - 001 NE: ~eq
  - 010 LT: lt_q
  - 011 GE: gt|eq
  - 100 GT: gt
  - 101 LE: lt_q|eq
  - 110 ALWAYS: 1
  - 111 NEVER: 0
- next_pc: taken ? pc+offset : pc+INC. Modulo 2^AW; overflow and wrap discarded, no flag.
- mispredict = taken ^ pred_taken, computed in the same cycle as taken.
- Latency: accepted branch appears on outputs the next cycle when the output register is empty or draining.
- Storage: output register (entry 0) plus skid register (entry 1).
  - in_ready = ~entry1_valid, registered, so it is not combinationally dependent on out_ready.
  - When the output is stalled (out_valid & ~out_ready) and an input is accepted, it goes to entry 1.
  - On drain, entry 1 moves to entry 0 in the same cycle it is freed.
- Occupancy states: EMPTY (0 held), ONE (entry 0), FULL (both).
  - EMPTY -> ONE on accept.
  - ONE -> FULL on accept without drain.
  - ONE -> EMPTY on drain without accept.
  - ONE -> ONE on simultaneous accept and drain.
  - FULL -> ONE on drain; in_ready is 0 while FULL.
- flush (highest priority over accept and drain): next cycle the state is EMPTY, out_valid=0, in_ready=1. An input handshaking in the flush cycle is discarded. Output data registers hold their values but are invalid.
- Illegal flag combinations (gt&eq, or none of gt/eq/lt asserted) are decoded per the table without special handling.
- Reset mid-operation clears all entries immediately, asynchronously.

Optional Feature:
- Macro BRANCH_RESOLVE_STATS_EN.
- When defined, adds two outputs:
  - stat_branches (16b): count of output transfers.
  - stat_mispred (16b): count of output transfers with mispredict=1.
- Both counters saturate at 16'hFFFF and reset to 0 on rst_n. flush does not clear them.
- When undefined, the ports and counters do not exist and the rest of the behaviour is identical.

Test Plan:
- Reset then cond=000, eq=1, gt=0, lt=1, pc=0x100, offset=0x20, pred_taken=0, out_ready=1 -> next cycle out_valid=1, taken=1, next_pc=0x120, mispredict=1.
- cond=010, eq=1, lt=1 (equal operands) -> taken=0, next_pc=pc+4. The lt&~eq qualification is exercised.
- Wrap: pc=0xFFFFFFF8, offset=0x10, cond=110 -> next_pc=0x00000008. Negative offset: pc=0x200, offset=0xFFFFFFF0, cond=110 -> next_pc=0x1F0.
- Backpressure: out_ready=0, issue 3 back-to-back branches -> first two accepted, in_ready=0 on the third. Release out_ready -> results emerge in order, one per cycle, no loss or duplication.
- FULL state, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1. The flushed input never appears on the output.
- With BRANCH_RESOLVE_STATS_EN: 5 branches, 2 mispredicted -> stat_branches=5, stat_mispred=2. Preload the counter near saturation and run more branches -> it stays at 0xFFFF.
